// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access unit.
// Holds the req_type codes, the sequencer state encoding and a helper that
// maps an access type to its size in bytes.
package mem_pkg;

  typedef enum logic [2:0] {
    RT_WORD  = 3'b000,
    RT_HALF  = 3'b001,
    RT_BYTE  = 3'b010,
    RT_UHALF = 3'b011,
    RT_UBYTE = 3'b100,
    RT_DWORD = 3'b101
  } req_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_RESP
  } state_e;

  // Access size in bytes; 0 marks an undefined type code (110, 111).
  function automatic logic [3:0] size_of(input logic [2:0] t);
    case (t)
      RT_WORD:            return 4'd4;
      RT_HALF, RT_UHALF:  return 4'd2;
      RT_BYTE, RT_UBYTE:  return 4'd1;
      RT_DWORD:           return 4'd8;
      default:            return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
//   m_req/m_we/m_addr/m_byteen/m_wdata : request, driven by the master
//   m_ack/m_rdata                       : beat accept and read data, from the slave
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W/8-1:0]   m_byteen;
  logic [DATA_W-1:0]     m_wdata;
  logic                  m_ack;
  logic [DATA_W-1:0]     m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_byteen, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_byteen, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the access unit.
//   offset, size, beat : byte offset inside a bus word, access size, beat index
//   wdata              : right-aligned store data
//   rtype              : access type, selects load extension
//   rbuf               : both captured read beats, beat 0 in the low half
//   byteen, lane_wdata : lane enables and lane-shifted store data for this beat
//   load_data          : extracted and extended load result
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  logic [3:0]                  size,
  input  logic                        beat,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [2:0]                  rtype,
  input  logic [2*DATA_W-1:0]         rbuf,
  output logic [DATA_W/8-1:0]         byteen,
  output logic [DATA_W-1:0]           lane_wdata,
  output logic [DATA_W-1:0]           load_data
);
  localparam int B = DATA_W / 8;

  // The access is laid out over two consecutive bus words; beat 0 drives the
  // lower word and beat 1 the upper one.
  logic [2*B-1:0]      wide_en;
  logic [2*DATA_W-1:0] wide_data;
  logic [2*DATA_W-1:0] shifted;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path infers a latch.
    wide_en    = '0;
    wide_data  = {{DATA_W{1'b0}}, wdata} << {offset, 3'b000};
    byteen     = '0;
    lane_wdata = '0;
    load_data  = '0;

    for (int i = 0; i < 2 * B; i++) begin
      wide_en[i] = (i >= int'(offset)) && (i < int'(offset) + int'(size));
      if (!wide_en[i]) wide_data[8*i +: 8] = 8'h00;
    end

    if (beat) begin
      byteen     = wide_en[2*B-1:B];
      lane_wdata = wide_data[2*DATA_W-1:DATA_W];
    end else begin
      byteen     = wide_en[B-1:0];
      lane_wdata = wide_data[DATA_W-1:0];
    end

    // The captured beats form one little-endian byte string, so the load
    // value always starts at byte 'offset' of the buffer.
    shifted = rbuf >> {offset, 3'b000};
    case (rtype)
      RT_BYTE:  load_data = DATA_W'($signed(shifted[7:0]));
      RT_UBYTE: load_data = DATA_W'(shifted[7:0]);
      RT_HALF:  load_data = DATA_W'($signed(shifted[15:0]));
      RT_UHALF: load_data = DATA_W'(shifted[15:0]);
      RT_WORD:  load_data = DATA_W'($signed(shifted[31:0]));  // MIPS64 lw sign-extends
      RT_DWORD: load_data = shifted[DATA_W-1:0];
      default:  load_data = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access sequencer. Accepts one load/store from the M-stage,
// runs one or two aligned beats on the data-memory bus and returns a
// one-cycle response, holding the pipeline through 'stall' meanwhile.
//   clk, reset                    : clock, synchronous active-high reset
//   req_*                         : M-stage request, held until resp_valid
//   req_ready, stall              : idle indication, pipeline freeze
//   resp_valid/resp_rdata/resp_err: completion pulse, load data, error flag
//   bus                           : data-memory bus, master side
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  mem_access_unit_if.master bus
);
  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);

  state_e              state, state_nx;
  logic [2:0]          type_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q, split_q, err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2*DATA_W-1:0] rbuf;

  // Decode of the incoming request, used only on the accept edge.
  logic [OFF_W-1:0] off_in;
  logic [3:0]       size_in;
  logic             illegal_in, misalign_in, bad_in, split_in;

  always_comb begin
    off_in      = req_addr[OFF_W-1:0];
    size_in     = size_of(req_type);
    // Wider-than-bus sizes cover DWORD on a 32-bit datapath.
    illegal_in  = (size_in == 4'd0) || (size_in > 4'(B));
    misalign_in = (int'(off_in) & (int'(size_in) - 1)) != 0;
    bad_in      = illegal_in || (MISALIGN_SPLIT == 0 && misalign_in);
    split_in    = (int'(off_in) + int'(size_in)) > B;
  end

  logic [ADDR_W-1:0]   base_addr;
  logic [B-1:0]        lane_en;
  logic [DATA_W-1:0]   lane_wdata, load_data;

  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .offset     (addr_q[OFF_W-1:0]),
    .size       (size_of(type_q)),
    .beat       (state == S_BEAT1),
    .wdata      (wdata_q),
    .rtype      (type_q),
    .rbuf       (rbuf),
    .byteen     (lane_en),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the read buffer is cleared as well; it is a plain register
      // array, not a RAM, so resetting it costs nothing in inference.
      type_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      rbuf    <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        type_q  <= req_type;
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
        split_q <= split_in && !bad_in;
        err_q   <= bad_in;
      end
      if (state == S_BEAT0 && bus.m_ack) rbuf[DATA_W-1:0]        <= bus.m_rdata;
      if (state == S_BEAT1 && bus.m_ack) rbuf[2*DATA_W-1:DATA_W] <= bus.m_rdata;
    end
  end

  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    bus.m_req    = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = '0;
    bus.m_byteen = '0;
    bus.m_wdata  = '0;

    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = bad_in ? S_RESP : S_BEAT0;
      end
      S_BEAT0, S_BEAT1: begin
        // Everything here comes from registers, so it holds while m_ack is low.
        bus.m_req    = 1'b1;
        bus.m_we     = write_q;
        bus.m_addr   = (state == S_BEAT1) ? base_addr + ADDR_W'(B) : base_addr;
        bus.m_byteen = lane_en;
        bus.m_wdata  = write_q ? lane_wdata : '0;
        if (bus.m_ack) state_nx = (state == S_BEAT0 && split_q) ? S_BEAT1 : S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || write_q) ? '0 : load_data;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign stall = req_valid && !resp_valid;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (32-bit datapath).
// A byte-addressed memory model answers the bus; expected beats, load values
// and latencies are derived per byte from the access rules.
module tb_mem_access_unit;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Unit with misaligned splitting
  logic          req_valid, req_write;
  logic [2:0]    req_type;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, stall, resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .MISALIGN_SPLIT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus(bus.master)
  );

  // Unit that reports misaligned accesses as errors
  logic          req_valid_n, req_write_n;
  logic [2:0]    req_type_n;
  logic [AW-1:0] req_addr_n;
  logic [DW-1:0] req_wdata_n;
  logic          req_ready_n, stall_n, resp_valid_n, resp_err_n;
  logic [DW-1:0] resp_rdata_n;
  mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .MISALIGN_SPLIT(0)) dut_n (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_n), .req_write(req_write_n), .req_type(req_type_n),
    .req_addr(req_addr_n), .req_wdata(req_wdata_n),
    .req_ready(req_ready_n), .stall(stall_n), .resp_valid(resp_valid_n),
    .resp_rdata(resp_rdata_n), .resp_err(resp_err_n),
    .bus(bus_n.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Byte memory; untouched locations read as a fixed address pattern.
  logic [7:0] mem [int unsigned];

  function automatic logic [7:0] rd_byte(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return 8'(a * 13 + 5);
  endfunction

  function automatic int size_bytes(input logic [2:0] t);
    case (t)
      3'd0:       return 4;
      3'd1, 3'd3: return 2;
      3'd2, 3'd4: return 1;
      default:    return 0;  // DWORD is illegal on 32 bits, 110/111 undefined
    endcase
  endfunction

  task automatic do_access(input bit wr, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] wd, input int delay, input string tag,
                           output logic [31:0] got_rdata);
    int          s, nb, exp_lat, cyc, bi, wcnt;
    bit          err, done;
    logic [31:0] base, exp_rd, raw, rdw;
    logic [3:0]  exp_en [2];
    logic [31:0] exp_wd [2];

    s = size_bytes(t);
    err = (s == 0);
    base = a & ~32'h3;
    exp_en[0] = '0; exp_en[1] = '0;
    exp_wd[0] = '0; exp_wd[1] = '0;
    nb = 0;
    raw = '0;
    for (int j = 0; j < s; j++) begin
      int unsigned ba;
      int k, lane;
      ba = a + j;
      k = int'((ba - base) / 4);
      lane = int'(ba % 4);
      exp_en[k][lane] = 1'b1;
      exp_wd[k][8*lane +: 8] = wd[8*j +: 8];
      if (k + 1 > nb) nb = k + 1;
      raw[8*j +: 8] = rd_byte(ba);
    end
    exp_rd = '0;
    if (!err && !wr) begin
      case (t)
        3'd0: exp_rd = raw;
        3'd1: exp_rd = {{16{raw[15]}}, raw[15:0]};
        3'd2: exp_rd = {{24{raw[7]}}, raw[7:0]};
        3'd3: exp_rd = {16'h0, raw[15:0]};
        default: exp_rd = {24'h0, raw[7:0]};
      endcase
    end
    exp_lat = err ? 1 : nb * (delay + 1) + 1;
    got_rdata = '0;

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_type = t; req_addr = a; req_wdata = wd;
    bus.m_ack = 1'b0;
    check({tag, "_ready"}, 64'(req_ready), 64'(1));
    @(posedge clk);
    cyc = 0; bi = 0; wcnt = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.m_ack = 1'b0;
      bus.m_rdata = '0;
      if (resp_valid) begin
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_err"}, 64'(resp_err), 64'(err));
        check({tag, "_rdata"}, 64'(resp_rdata), 64'(exp_rd));
        check({tag, "_beats"}, 64'(bi), 64'(err ? 0 : nb));
        check({tag, "_stall_low"}, 64'(stall), 64'(0));
        got_rdata = resp_rdata;
        req_valid = 1'b0;
        done = 1'b1;
      end else if (bus.m_req) begin
        check({tag, "_stall"}, 64'(stall), 64'(1));
        if (err || bi >= nb) begin
          check({tag, "_extra_beat"}, 64'(bi), 64'(err ? -1 : nb));
          req_valid = 1'b0;
          done = 1'b1;
        end else begin
          check({tag, "_addr"}, 64'(bus.m_addr), 64'(base + 32'(4 * bi)));
          check({tag, "_byteen"}, 64'(bus.m_byteen), 64'(exp_en[bi]));
          check({tag, "_we"}, 64'(bus.m_we), 64'(wr));
          check({tag, "_wdata"}, 64'(bus.m_wdata), 64'(wr ? exp_wd[bi] : 32'h0));
          if (wcnt == delay) begin
            for (int l = 0; l < 4; l++) rdw[8*l +: 8] = rd_byte(bus.m_addr + 32'(l));
            bus.m_rdata = rdw;
            bus.m_ack = 1'b1;
            if (wr)
              for (int l = 0; l < 4; l++)
                if (bus.m_byteen[l]) mem[bus.m_addr + 32'(l)] = bus.m_wdata[8*l +: 8];
            bi++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'(cyc), 64'(exp_lat));
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_type = '0; req_addr = '0; req_wdata = '0;
    req_valid_n = 1'b0; req_write_n = 1'b0; req_type_n = '0; req_addr_n = '0; req_wdata_n = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    bus_n.m_ack = 1'b0; bus_n.m_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_m_req", 64'(bus.m_req), 64'(0));
    check("rst_m_we", 64'(bus.m_we), 64'(0));
    check("rst_m_addr", 64'(bus.m_addr), 64'(0));
    check("rst_m_byteen", 64'(bus.m_byteen), 64'(0));
    check("rst_m_wdata", 64'(bus.m_wdata), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_err", 64'(resp_err), 64'(0));
    check("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    check("rst_stall_hi", 64'(stall), 64'(1));
    req_valid = 1'b0;
    #1 check("rst_stall_lo", 64'(stall), 64'(0));
    reset = 1'b0;

    // Aligned store
    do_access(1'b1, 3'd0, 32'h100, 32'hDEADBEEF, 0, "st_word", r);
    check("st_word_mem", 64'({mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]}),
          64'(32'hDEADBEEF));

    // Byte loads from a word reading 0x80FFFF00
    mem[32'h100] = 8'h00; mem[32'h101] = 8'hFF; mem[32'h102] = 8'hFF; mem[32'h103] = 8'h80;
    do_access(1'b0, 3'd2, 32'h103, 32'h0, 0, "ld_byte", r);
    check("ld_byte_value", 64'(r), 64'(32'hFFFFFF80));
    do_access(1'b0, 3'd4, 32'h103, 32'h0, 0, "ld_ubyte", r);
    check("ld_ubyte_value", 64'(r), 64'(32'h00000080));

    // Split store
    do_access(1'b1, 3'd1, 32'h203, 32'h00001234, 0, "st_split", r);
    check("st_split_mem", 64'({mem[32'h204], mem[32'h203]}), 64'(16'h1234));

    // Split load: beat0 reads 0xBBAA0000, beat1 reads 0x0000DDCC
    mem[32'h100] = 8'h00; mem[32'h101] = 8'h00; mem[32'h102] = 8'hAA; mem[32'h103] = 8'hBB;
    mem[32'h104] = 8'hCC; mem[32'h105] = 8'hDD; mem[32'h106] = 8'h00; mem[32'h107] = 8'h00;
    do_access(1'b0, 3'd0, 32'h102, 32'h0, 0, "ld_split", r);
    check("ld_split_value", 64'(r), 64'(32'hDDCCBBAA));

    // Same misaligned load on the non-splitting unit: error after one cycle
    @(negedge clk);
    req_valid_n = 1'b1; req_type_n = 3'd0; req_addr_n = 32'h102;
    check("ns_ready", 64'(req_ready_n), 64'(1));
    @(posedge clk);
    @(negedge clk);
    check("ns_resp_valid", 64'(resp_valid_n), 64'(1));
    check("ns_resp_err", 64'(resp_err_n), 64'(1));
    check("ns_resp_rdata", 64'(resp_rdata_n), 64'(0));
    check("ns_no_m_req", 64'(bus_n.m_req), 64'(0));
    check("ns_stall", 64'(stall_n), 64'(0));
    req_valid_n = 1'b0;
    @(negedge clk);
    check("ns_back_idle", 64'(req_ready_n), 64'(1));
    check("ns_single_resp", 64'(resp_valid_n), 64'(0));

    // Delayed ack on a load: beats held stable, response after 5 cycles
    do_access(1'b0, 3'd0, 32'h100, 32'h0, 3, "ld_delay", r);

    // Reset during BEAT1 of a split store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_type = 3'd1; req_addr = 32'h203; req_wdata = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    check("rm_beat0_req", 64'(bus.m_req), 64'(1));
    bus.m_ack = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
    check("rm_beat1_addr", 64'(bus.m_addr), 64'(32'h204));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    check("rm_m_req", 64'(bus.m_req), 64'(0));
    check("rm_ready", 64'(req_ready), 64'(1));
    check("rm_no_resp", 64'(resp_valid), 64'(0));
    bus.m_ack = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
    check("rm_stray_ready", 64'(req_ready), 64'(1));
    check("rm_stray_m_req", 64'(bus.m_req), 64'(0));
    check("rm_stray_no_resp", 64'(resp_valid), 64'(0));

    // Randomized accesses, including illegal types
    for (int n = 0; n < 40; n++) begin
      bit          rwr;
      logic [2:0]  rt;
      logic [31:0] ra, rwd;
      int          rdl;
      rwr = 1'($urandom_range(0, 1));
      rt  = 3'($urandom_range(0, 7));
      ra  = 32'h300 + 32'($urandom_range(0, 63));
      rwd = $urandom;
      rdl = int'($urandom_range(0, 2));
      do_access(rwr, rt, ra, rwd, rdl, $sformatf("rnd%0d", n), r);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
